// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: command-driven burst sequencer in front of a small
// synchronous RAM. It accepts single or burst read/write commands,
// streams write beats into the RAM, and returns read beats with explicit
// valid/last flags that absorb the RAM's one-cycle registered read latency.
module sync_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] beats_left_q, beats_left_d;
  logic              rd_issue_q, rd_issue_d;
  logic              rd_last_q, rd_last_d;

  // Next-state and RAM-pin decode; reset forces every handshake/enable low
  // so nothing is accepted or written while the block is being cleared.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_issue_d   = 1'b0;
    rd_last_d    = 1'b0;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = cur_addr_q;
    ram_din      = wr_data;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
          state_d      = cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (beats_left_q == '0) begin
            state_d = IDLE;
          end else begin
            beats_left_d = beats_left_q - ADDR_W'(1);
          end
        end
      end
      READ: begin
        rd_issue_d = 1'b1;
        rd_last_d  = (beats_left_q == '0);
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        if (beats_left_q == '0) begin
          state_d = IDLE;
        end else begin
          beats_left_d = beats_left_q - ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      ram_we    = 1'b0;
    end
  end

  // State and burst bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_issue_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_issue_q   <= rd_issue_d;
      rd_last_q    <= rd_last_d;
    end
  end

  assign rd_valid = rd_issue_q & ~rst;
  assign rd_last  = rd_last_q & ~rst;
  assign rd_data  = ram_dout;
  assign busy     = (state_q != IDLE) & ~rst;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Testbench for sync_ram_ctrl: includes a behavioural 4x8 synchronous RAM
// and checks the controller against a word-level memory model.
module tb_sync_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [1:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_last, busy;
  logic [7:0] rd_data;
  logic       ram_we;
  logic [1:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [4];
  logic [7:0] ref_mem [4];

  int checks   = 0;
  int failures = 0;
  int we_cycles = 0;

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous RAM: a write cycle leaves dout untouched.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  // Count cycles in which the RAM is told to write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) we_cycles++;
  end

  // Single comparison point for every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer a command and wait (bounded) for the handshake edge.
  task automatic applyStimulus(input logic we, input logic [1:0] addr,
                               input logic [1:0] len);
    bit done = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = 2'($urandom);
    cmd_len   = 2'($urandom);
    checkOutput("cmd_accept", 32'(done), 32'd1);
  endtask

  // Write burst: gaps_pk holds per-beat idle cycles (2 bits per beat).
  task automatic doWrite(input logic [1:0] addr, input logic [1:0] len,
                         input logic [31:0] data_pk, input logic [7:0] gaps_pk,
                         input bit accepted);
    int beats = int'(len) + 1;
    if (!accepted) applyStimulus(1'b1, addr, len);
    for (int i = 0; i < beats; i++) begin
      int g = int'(gaps_pk[2*i +: 2]);
      logic [7:0] d = data_pk[8*i +: 8];
      int a = (int'(addr) + i) % 4;
      for (int j = 0; j < g; j++) begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
        @(negedge clk);
        checkOutput("wr_gap_we", 32'(ram_we), 32'd0);
        checkOutput("wr_gap_busy", 32'(busy), 32'd1);
        checkOutput("wr_gap_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      checkOutput("wr_we", 32'(ram_we), 32'd1);
      checkOutput("wr_addr", 32'(ram_addr), 32'(a));
      checkOutput("wr_din", 32'(ram_din), 32'(d));
      checkOutput("wr_busy", 32'(busy), 32'd1);
      checkOutput("wr_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("wr_rd_valid", 32'(rd_valid), 32'd0);
      @(posedge clk);
      ref_mem[a] = d;
      #1;
    end
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
    @(negedge clk);
    checkOutput("wr_end_busy", 32'(busy), 32'd0);
    checkOutput("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("wr_end_we", 32'(ram_we), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Read burst; optionally holds a write command pending during the burst.
  task automatic doRead(input logic [1:0] addr, input logic [1:0] len,
                        input bit chain, input logic [1:0] chain_addr,
                        input logic [1:0] chain_len);
    logic [7:0] exp_q[$];
    int beats = int'(len) + 1;
    applyStimulus(1'b0, addr, len);
    for (int i = 0; i < beats; i++) exp_q.push_back(ref_mem[(int'(addr) + i) % 4]);
    if (chain) begin
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = chain_addr;
      cmd_len   = chain_len;
    end
    for (int k = 0; k <= beats; k++) begin
      @(negedge clk);
      if (k < beats) begin
        checkOutput("rd_issue_addr", 32'(ram_addr), 32'((int'(addr) + k) % 4));
        checkOutput("rd_issue_we", 32'(ram_we), 32'd0);
        checkOutput("rd_busy", 32'(busy), 32'd1);
        checkOutput("rd_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rd_wr_ready", 32'(wr_ready), 32'd0);
      end else begin
        checkOutput("rd_end_busy", 32'(busy), 32'd0);
        checkOutput("rd_end_cmd_ready", 32'(cmd_ready), 32'd1);
      end
      if (k == 0) begin
        checkOutput("rd_valid_early", 32'(rd_valid), 32'd0);
      end else begin
        checkOutput("rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("rd_data", 32'(rd_data), 32'(exp_q[k-1]));
        checkOutput("rd_last", 32'(rd_last), 32'(k == beats));
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!chain) begin
      @(negedge clk);
      checkOutput("rd_valid_after", 32'(rd_valid), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    int wc0;
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 8'hC0 + 8'(i);
      ref_mem[i] = 8'hC0 + 8'(i);
    end
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd0;
    wr_valid = 1'b0; wr_data = 8'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("idle_ram_we", 32'(ram_we), 32'd0);
    checkOutput("idle_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] single write then read");
    doWrite(2'd1, 2'd0, 32'h0000_00A5, 8'h00, 1'b0);
    doRead(2'd1, 2'd0, 1'b0, 2'd0, 2'd0);

    $display("[TB] wrapping burst write and read");
    doWrite(2'd2, 2'd3, 32'h4433_2211, 8'h00, 1'b0);
    doRead(2'd0, 2'd3, 1'b0, 2'd0, 2'd0);

    $display("[TB] write with gaps");
    wc0 = we_cycles;
    doWrite(2'd0, 2'd1, 32'h0000_6B5A, 8'b0000_1000, 1'b0);
    checkOutput("gap_write_count", 32'(we_cycles - wc0), 32'd2);
    doRead(2'd0, 2'd3, 1'b0, 2'd0, 2'd0);

    $display("[TB] busy rejection with pending write");
    doRead(2'd1, 2'd3, 1'b1, 2'd3, 2'd0);
    doWrite(2'd3, 2'd0, 32'h0000_00E7, 8'h00, 1'b1);
    doRead(2'd3, 2'd0, 1'b0, 2'd0, 2'd0);

    $display("[TB] reset in the middle of a write burst");
    applyStimulus(1'b1, 2'd0, 2'd3);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i + 1);
      @(posedge clk);
      ref_mem[i] = 8'(i + 1);
      #1;
    end
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h03;
    @(negedge clk);
    checkOutput("rstw_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rstw_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rstw_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rstw_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rstw_rd_last", 32'(rd_last), 32'd0);
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstw_after_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rstw_after_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    doRead(2'd0, 2'd3, 1'b0, 2'd0, 2'd0);

    $display("[TB] reset in the middle of a read burst");
    applyStimulus(1'b0, 2'd0, 2'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstr_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rstr_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstr_after_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rstr_after_rd_last", 32'(rd_last), 32'd0);
    checkOutput("rstr_after_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] back-to-back read then write");
    doRead(2'd2, 2'd0, 1'b1, 2'd2, 2'd0);
    doWrite(2'd2, 2'd0, 32'h0000_009C, 8'h00, 1'b1);
    doRead(2'd2, 2'd0, 1'b0, 2'd0, 2'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      logic [1:0] a = 2'($urandom);
      logic [1:0] l = 2'($urandom);
      logic [31:0] d = $urandom;
      logic [7:0] g = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 1) == 1) begin
        doWrite(a, l, d, g, 1'b0);
      end else if ($urandom_range(0, 2) == 0) begin
        logic [1:0] ca = 2'($urandom);
        logic [1:0] cl = 2'($urandom);
        doRead(a, l, 1'b1, ca, cl);
        doWrite(ca, cl, d, g, 1'b1);
      end else begin
        doRead(a, l, 1'b0, 2'd0, 2'd0);
      end
    end
    doRead(2'd0, 2'd3, 1'b0, 2'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
